// File: rtl/regfile_scoreboard.sv
// Architectural register file fed by writeback, with per-register in-flight
// write counters that stall decode on read-after-write hazards bypass cannot cover.
module regfile_scoreboard #(
  parameter int word_size = 32,
  parameter int reg_size  = 5,
  parameter int cnt_width = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RegWrite,
  input  logic [reg_size-1:0]  WriteReg,
  input  logic [word_size-1:0] WriteData,
  input  logic [reg_size-1:0]  rs1,
  input  logic [reg_size-1:0]  rs2,
  output logic [word_size-1:0] rd1,
  output logic [word_size-1:0] rd2,
  input  logic                 issue_valid,
  input  logic                 issue_regwrite,
  input  logic [reg_size-1:0]  issue_rd,
  output logic                 stall,
  output logic                 sb_err
);
  localparam int NREG = 2 ** reg_size;
  localparam logic [cnt_width-1:0] CNT_MAX = '1;
  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  logic [word_size-1:0] reg_q [NREG];
  logic [word_size-1:0] reg_d [NREG];
  logic [cnt_width-1:0] cnt_q [NREG];
  logic [cnt_width-1:0] cnt_d [NREG];
  logic                 sb_err_q, sb_err_d;
  logic [NREG-1:0]      retire_hit, accept_hit;
  logic                 wb_en, accept, busy_a, busy_b;

  assign wb_en = RegWrite && (WriteReg != '0);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
      assign retire_hit[gi] = wb_en && (WriteReg == reg_size'(gi));
      assign accept_hit[gi] = accept && (issue_rd == reg_size'(gi));
    end
  endgenerate

  // A single outstanding writer that retires this cycle is forwarded, so it is not a hazard.
  assign busy_a = (rs1 != '0) &&
                  ((cnt_q[rs1] > CNT_ONE) || ((cnt_q[rs1] == CNT_ONE) && !retire_hit[rs1]));
  assign busy_b = (rs2 != '0) &&
                  ((cnt_q[rs2] > CNT_ONE) || ((cnt_q[rs2] == CNT_ONE) && !retire_hit[rs2]));

  assign stall  = issue_valid && (busy_a || busy_b);
  assign accept = issue_valid && !stall && issue_regwrite && (issue_rd != '0);

  assign rd1 = (rs1 == '0) ? '0 : (wb_en && (WriteReg == rs1)) ? WriteData : reg_q[rs1];
  assign rd2 = (rs2 == '0) ? '0 : (wb_en && (WriteReg == rs2)) ? WriteData : reg_q[rs2];
  assign sb_err = sb_err_q;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      reg_d[i] = reg_q[i];
    end
    if (wb_en) begin
      reg_d[WriteReg] = WriteData;
    end
  end

  // Counters saturate at both ends; an over/underflow attempt latches the error flag.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept_hit[i] && !retire_hit[i]) begin
        if (cnt_q[i] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (retire_hit[i] && !accept_hit[i]) begin
        if (cnt_q[i] == '0) sb_err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= reg_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver predicts each cycle's outputs from an array/counter model,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] rd1, rd2;
  logic        issue_valid = 1'b0, issue_regwrite = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        stall, sb_err;

  typedef struct {
    int          id;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [31:0] mreg [32];
  int          mcnt [32];
  bit          merr;

  regfile_scoreboard #(.word_size(32), .reg_size(5), .cnt_width(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
    .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mcnt[i] = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input bit rw,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return '0;
    if (rw && wa == r) return wd;
    return mreg[r];
  endfunction

  // An operand is a hazard when more writers are pending than are retiring right now.
  function automatic bit model_busy(input logic [4:0] r, input bit rw, input logic [4:0] wa);
    int pending;
    if (r == 0) return 1'b0;
    pending = mcnt[r] - ((rw && wa == r) ? 1 : 0);
    return pending > 0;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b,
                       input bit iv, input bit irw, input logic [4:0] ird);
    exp_t e;
    bit   acc;
    int   n;
    RegWrite = rw; WriteReg = wa; WriteData = wd;
    rs1 = a; rs2 = b;
    issue_valid = iv; issue_regwrite = irw; issue_rd = ird;
    e.id    = pushed;
    e.rd1   = model_read(a, rw, wa, wd);
    e.rd2   = model_read(b, rw, wa, wd);
    e.stall = iv && (model_busy(a, rw, wa) || model_busy(b, rw, wa));
    e.err   = merr;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    acc = iv && !e.stall && irw && ird != 0;
    for (int r = 1; r < 32; r++) begin
      n = mcnt[r] + ((acc && ird == r) ? 1 : 0) - ((rw && wa == r) ? 1 : 0);
      if (n < 0) begin
        n = 0;
        merr = 1'b1;
      end else if (n > MAXC) begin
        n = MAXC;
        merr = 1'b1;
      end
      mcnt[r] = n;
    end
    if (rw && wa != 0) mreg[wa] = wd;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("rd1",    e.id, rd1, e.rd1);
        chk("rd2",    e.id, rd2, e.rd2);
        chk("stall",  e.id, {31'b0, stall},  {31'b0, e.stall});
        chk("sb_err", e.id, {31'b0, sb_err}, {31'b0, e.err});
        $display("txn %0d rs1=%0d rs2=%0d rd1=%h rd2=%h stall=%b sb_err=%b",
                 e.id, rs1, rs2, rd1, rd2, stall, sb_err);
      end
    end
  end

  initial begin : driver
    logic [4:0] ra, rb, rw_idx, ir;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cycle(0, 0, 0, 5, 0, 0, 0, 0);
    cycle(1, 3, 32'hDEADBEEF, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 3, 0, 0, 0, 0);
    cycle(1, 0, 32'h1234, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 7);
    cycle(0, 0, 0, 0, 7, 1, 0, 0);
    cycle(1, 7, 32'h55, 0, 7, 1, 0, 0);
    cycle(0, 0, 0, 0, 7, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 1, 9);
    cycle(0, 0, 0, 9, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 9);
    cycle(1, 9, 32'hA5A5, 0, 0, 1, 1, 9);
    cycle(0, 0, 0, 9, 0, 1, 0, 0);
    cycle(1, 9, 32'h1, 0, 9, 1, 0, 0);
    cycle(0, 0, 0, 9, 3, 1, 0, 0);
    pulse_reset();
    cycle(1, 4, 32'h44, 4, 3, 0, 0, 0);
    cycle(0, 0, 0, 4, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 9);
    pulse_reset();
    cycle(0, 0, 0, 4, 3, 1, 0, 9);

    for (int k = 0; k < 1500; k++) begin
      if (k % 60 == 59) pulse_reset();
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rw_idx = 5'($urandom_range(0, 7));
      ir = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 2) == 0, rw_idx, $urandom, ra, rb,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, ir);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain: got %0d popped with %0d queued, required %0d popped with 0 queued",
               popped, exp_q.size(), pushed);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL timeout: got no completion, required completion before 2000000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file that is the receiving end of the writeback interface. It sinks RegWrite/WriteReg/WriteData from the WB stage and serves two read ports to the decode (ID) stage.
- Adds per-register in-flight write counters (scoreboard). These drive a decode stall for read-after-write hazards that bypass cannot cover.
- Sits between the WB stage output and the ID stage operand fetch / issue logic.

Parameters:
- word_size, 32, data width of each register
- reg_size, 5, register index width; register count is 2**reg_size
- cnt_width, 2, width of each in-flight counter; maximum count is 2**cnt_width-1

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- RegWrite  input  1  write enable from WB stage
- WriteReg  input  reg_size  destination index from WB stage
- WriteData  input  word_size  write data from WB stage
- rs1  input  reg_size  ID read index A
- rs2  input  reg_size  ID read index B
- rd1  output  word_size  read data A (combinational)
- rd2  output  word_size  read data B (combinational)
- issue_valid  input  1  ID presents an instruction for issue this cycle
- issue_regwrite  input  1  issuing instruction will write a register
- issue_rd  input  reg_size  destination of issuing instruction
- stall  output  1  ID must hold; issue is not accepted this cycle
- sb_err  output  1  sticky scoreboard error flag

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all counters = 0, sb_err = 0. With the write port idle, rd1/rd2 therefore read 0.
- Register 0 is hardwired:
  - Never written.
  - Always reads 0.
  - Never counted.
  - Never causes a stall.
- Write: on the rising edge, if RegWrite=1 and WriteReg!=0, then reg[WriteReg] <= WriteData.
- Read (combinational, zero latency):
  - rdN = 0 if rsN==0.
  - Else rdN = WriteData if RegWrite=1 and WriteReg==rsN (write-through bypass).
  - Else rdN = reg[rsN].
- retire_hit(r): RegWrite=1 and WriteReg==r and r!=0.
- Stall: stall=1 iff issue_valid=1 and, for rs1 or rs2 (r!=0):
  - cnt[r] >= 2, or
  - cnt[r] == 1 and not retire_hit(r).
  - A retiring last writer is covered by bypass, so it causes no stall.
- Issue accepted: accept = issue_valid and not stall and issue_regwrite and issue_rd!=0.
- Counter update per register r, at the rising edge:
  - accept to r only: cnt+1.
  - retire to r only: cnt-1.
  - Both in the same cycle: cnt unchanged.
  - Neither: hold.
- Error cases (counter saturates/floors):
  - Retire to r with cnt[r]==0 and no simultaneous accept to r: counter stays 0, sb_err <= 1.
  - Accept to r with cnt[r]==max and no simultaneous retire to r: counter stays max, sb_err <= 1.
  - sb_err clears only on reset.
- stall depends only on current inputs and state; it has no effect on the WB write path.
- Reset asserted mid-operation: all state clears immediately. Any WB write in the same cycle is lost.
- Rs/rd collisions with issue_rd in the same cycle do not stall. Issue is evaluated against pre-update counters.

Test Plan:
- Reset then read rs1=5, rs2=0 -> rd1=0, rd2=0, stall=0, sb_err=0.
- WB write RegWrite=1, WriteReg=3, WriteData=0xDEADBEEF with rs1=3 in the same cycle -> rd1=0xDEADBEEF (bypass); the next cycle with RegWrite=0 -> rd1=0xDEADBEEF from storage.
- Write WriteReg=0, WriteData=0x1234 -> rs1=0 reads 0; issue_rd=0 leaves no counter change and never stalls.
- Issue rd=7 (cnt 0->1); next cycle issue_valid with rs2=7 -> stall=1. Same cycle with RegWrite, WriteReg=7, WriteData=0x55 -> stall=0, rd2=0x55, cnt 1->0.
- Issue rd=9 three times (cnt=3); then a fourth issue rd=9 with rs=0 -> counter stays 3, sb_err=1. Simultaneous issue rd=9 and retire 9 -> cnt unchanged.
- Retire WriteReg=4 with cnt[4]=0 -> sb_err=1 and held. Pulse rst_n low mid-cycle -> registers, counters and sb_err clear immediately without waiting for a clock edge.
